// File: rtl/gray_sync_pkg.sv
// Shared definitions for the Gray-pointer synchroniser.
//   g2b / b2g / popcount operate on a zero-extended word so that any pointer
//   width up to PTR_MAX_W can use them; upper zero bits do not change the result.
//   sync_state_t holds the warm-up / run state encoding.
package gray_sync_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } sync_state_t;

    function automatic ptr_word_t g2b(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_word_t b2g(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic int popcount(input ptr_word_t v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            cnt += int'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Bare multi-flop synchroniser chain for a Gray-coded pointer.
// Nothing else lives here so CDC/synthesis attributes can target this module alone.
//   clk    in  1   destination-domain clock
//   rst_n  in  1   synchronous active-low reset
//   d      in  N   asynchronous Gray pointer
//   q      out N   output of the last stage (STAGES edges after d)
module gray_sync_chain #(
    parameter int N      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchroniser for async FIFO pointer crossing, destination side.
// Synchronises the pointer, converts it to binary, reports the modular advance
// and flags/counts multi-bit steps. Pulses are masked until the chain and the
// output stage hold real post-reset data.
//   clk        in  1      destination-domain clock
//   rst_n      in  1      synchronous active-low reset
//   gray_in    in  N      Gray pointer from the source domain
//   clr_err    in  1      clears err_cnt (wins over a coincident increment)
//   sync_gray  out N      last synchroniser stage
//   sync_bin   out N      registered binary of sync_gray
//   bin_delta  out N      (new - old) mod 2^N of the synced binary pointer
//   changed    out 1      pulse: synced pointer moved
//   gray_err   out 1      pulse: more than one bit changed between samples
//   err_cnt    out ERR_W  saturating count of gray_err pulses
//   ready      out 1      warm-up complete
//
// state     | meaning
// ST_WARMUP | wcnt counts 0..STAGES; changed/gray_err/bin_delta held at 0
// ST_RUN    | normal reporting; ready=1 until the next reset
module gray_ptr_sync
    import gray_sync_pkg::*;
#(
    parameter int N      = 4,
    parameter int STAGES = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     gray_in,
    input  logic             clr_err,
    output logic [N-1:0]     sync_gray,
    output logic [N-1:0]     sync_bin,
    output logic [N-1:0]     bin_delta,
    output logic             changed,
    output logic             gray_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             ready
);

    localparam int                WCNT_W    = $clog2(STAGES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(STAGES);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    sync_state_t       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [N-1:0]      gray_prev;
    logic [N-1:0]      bin_now;
    logic [N-1:0]      diff;
    logic              violation;

    logic              ready_d;
    logic              changed_d;
    logic              gray_err_d;
    logic [N-1:0]      bin_delta_d;
    logic [ERR_W-1:0]  err_cnt_d;

    gray_sync_chain #(
        .N      (N),
        .STAGES (STAGES)
    ) u_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gray_in),
        .q     (sync_gray)
    );

    assign bin_now   = N'(g2b(ptr_word_t'(sync_gray)));
    assign diff      = sync_gray ^ gray_prev;
    assign violation = popcount(ptr_word_t'(diff)) > 1;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        ready_d     = ready;
        changed_d   = 1'b0;
        gray_err_d  = 1'b0;
        bin_delta_d = '0;
        err_cnt_d   = err_cnt;

        case (state_q)
            ST_WARMUP: begin
                if (wcnt_q == WCNT_LAST) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                ready_d     = 1'b1;
                changed_d   = |diff;
                gray_err_d  = violation;
                // sync_bin always equals g2b(gray_prev), so this is new - old.
                bin_delta_d = bin_now - sync_bin;
            end
        endcase

        if (clr_err) begin
            err_cnt_d = '0;
        end else if (gray_err_d && (err_cnt != ERR_MAX)) begin
            err_cnt_d = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_WARMUP;
            wcnt_q    <= '0;
            gray_prev <= '0;
            sync_bin  <= '0;
            bin_delta <= '0;
            changed   <= 1'b0;
            gray_err  <= 1'b0;
            err_cnt   <= '0;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            gray_prev <= sync_gray;
            sync_bin  <= bin_now;
            bin_delta <= bin_delta_d;
            changed   <= changed_d;
            gray_err  <= gray_err_d;
            err_cnt   <= err_cnt_d;
            ready     <= ready_d;
        end
    end

endmodule
